// File: rtl/hub75_rx_capture.sv
// HUB75 receive capture: oversamples the panel bus on clk, rebuilds bit planes into full-depth
// pixels and replays each completed row on a framebuffer write port.
module hub75_rx_capture #(
  parameter int hpixel_p      = 64,
  parameter int vpixel_p      = 64,
  parameter int bpp_p         = 8,
  parameter int segments_p    = 2,
  parameter int sync_stages_p = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   i_enable,
  input  logic                                   I_CLK,
  input  logic                                   I_STB,
  input  logic                                   I_OE,
  input  logic                                   I_A,
  input  logic                                   I_B,
  input  logic                                   I_C,
  input  logic                                   I_D,
  input  logic                                   I_E,
  input  logic                                   I_R1,
  input  logic                                   I_G1,
  input  logic                                   I_B1,
  input  logic                                   I_R2,
  input  logic                                   I_G2,
  input  logic                                   I_B2,
  output logic [$clog2(hpixel_p*vpixel_p)-1:0]   o_wr_addr,
  output logic [3*bpp_p-1:0]                     o_wr_data,
  output logic                                   o_wr_en,
  output logic                                   o_frame_done,
  output logic                                   o_err,
  output logic                                   o_busy
);

  localparam int rps_c     = vpixel_p / segments_p;
  localparam int lanes_c   = segments_p * 3;
  localparam int npix_c    = segments_p * hpixel_p;
  localparam int addr_w_c  = $clog2(hpixel_p * vpixel_p);
  localparam int col_w_c   = $clog2(hpixel_p + 1);
  localparam int plane_w_c = (bpp_p > 1) ? $clog2(bpp_p) : 1;
  localparam int row_w_c   = (rps_c > 1) ? $clog2(rps_c) : 1;
  localparam int idx_w_c   = (npix_c > 1) ? $clog2(npix_c) : 1;
  localparam int nin_c     = 14;
  localparam int pin_clk_c = 0;
  localparam int pin_stb_c = 1;
  localparam int pin_oe_c  = 2;
  localparam int pin_e_c   = 3;
  localparam int pin_r1_c  = 8;

  // state    | meaning
  // ST_IDLE  | disabled, counters and error cleared, bus ignored
  // ST_SHIFT | shifting columns, merging planes on each latch
  // ST_DUMP  | replaying the completed row, one pixel per cycle
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DUMP} state_t;

  logic [nin_c-1:0]     pins;
  logic [nin_c-1:0]     sync_q [sync_stages_p];
  logic [nin_c-1:0]     sync_d [sync_stages_p];
  logic [nin_c-1:0]     samp_q, samp_d;
  logic                 clk_rise_q, clk_rise_d;
  logic                 stb_rise_q, stb_rise_d;

  state_t               state_q, state_d;
  logic [hpixel_p-1:0]  sr_q [lanes_c];
  logic [hpixel_p-1:0]  sr_d [lanes_c];
  logic [bpp_p-1:0]     rb_q [npix_c*3];
  logic [bpp_p-1:0]     rb_d [npix_c*3];
  logic [col_w_c-1:0]   col_q, col_d;
  logic [plane_w_c-1:0] plane_q, plane_d;
  logic [row_w_c-1:0]   row_q, row_d;
  logic                 row_vld_q, row_vld_d;
  logic [idx_w_c-1:0]   idx_q, idx_d;
  logic                 err_q, err_d;
  logic                 wr_en_q, wr_en_d;
  logic                 busy_q, busy_d;
  logic [addr_w_c-1:0]  wr_addr_q, wr_addr_d;
  logic [3*bpp_p-1:0]   wr_data_q, wr_data_d;
  logic                 fd_pend_q, fd_pend_d;
  logic                 frame_done_q, frame_done_d;

  logic [plane_w_c-1:0] plane_eff;
  logic [row_w_c-1:0]   latch_row;
  int                   dump_seg;
  int                   dump_col;
  int                   dump_base;

  // Row select packs as {A,B,C,D,E}, so E is the lowest row bit.
  assign pins = {I_B2, I_G2, I_R2, I_B1, I_G1, I_R1,
                 I_A, I_B, I_C, I_D, I_E, I_OE, I_STB, I_CLK};

  always_comb begin
    sync_d[0] = pins;
    for (int i = 1; i < sync_stages_p; i++) sync_d[i] = sync_q[i-1];
    samp_d     = sync_q[sync_stages_p-1];
    clk_rise_d = sync_q[sync_stages_p-1][pin_clk_c] & ~samp_q[pin_clk_c];
    stb_rise_d = sync_q[sync_stages_p-1][pin_stb_c] & ~samp_q[pin_stb_c];
  end

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    rb_d         = rb_q;
    col_d        = col_q;
    plane_d      = plane_q;
    row_d        = row_q;
    row_vld_d    = row_vld_q;
    idx_d        = idx_q;
    err_d        = err_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    fd_pend_d    = 1'b0;
    frame_done_d = fd_pend_q;
    plane_eff    = plane_q;
    latch_row    = samp_q[pin_e_c +: row_w_c];
    dump_seg     = 0;
    dump_col     = 0;
    dump_base    = 0;

    // Shift happens before any latch in the same cycle, so the latch sees the updated column count.
    if (state_q != ST_IDLE && clk_rise_q) begin
      for (int l = 0; l < lanes_c; l++)
        sr_d[l] = {sr_q[l][hpixel_p-2:0], samp_q[pin_r1_c + l]};
      if (col_q != col_w_c'(hpixel_p)) col_d = col_q + 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        col_d     = '0;
        plane_d   = '0;
        idx_d     = '0;
        row_vld_d = 1'b0;
        err_d     = 1'b0;
        if (i_enable) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (stb_rise_q) begin
          if (!samp_q[pin_oe_c]) err_d = 1'b1;
          if (!row_vld_q || latch_row != row_q) plane_eff = '0;
          row_d     = latch_row;
          row_vld_d = 1'b1;
          if (col_d != col_w_c'(hpixel_p)) begin
            err_d   = 1'b1;
            plane_d = '0;
          end else begin
            for (int s = 0; s < segments_p; s++)
              for (int c = 0; c < hpixel_p; c++)
                for (int k = 0; k < 3; k++)
                  rb_d[(s*hpixel_p + c)*3 + k][plane_eff] = sr_d[s*3 + k][c];
            if (plane_eff == plane_w_c'(bpp_p-1)) begin
              plane_d = '0;
              state_d = ST_DUMP;
            end else begin
              plane_d = plane_eff + 1'b1;
            end
          end
          col_d = '0;
        end
      end
      ST_DUMP: begin
        if (stb_rise_q) err_d = 1'b1;
        dump_seg  = int'(idx_q) / hpixel_p;
        dump_col  = int'(idx_q) % hpixel_p;
        dump_base = (dump_seg*hpixel_p + dump_col) * 3;
        wr_en_d   = 1'b1;
        wr_addr_d = addr_w_c'((dump_seg*rps_c + int'(row_q))*hpixel_p + dump_col);
        wr_data_d = {rb_q[dump_base], rb_q[dump_base+1], rb_q[dump_base+2]};
        if (idx_q == idx_w_c'(npix_c-1)) begin
          idx_d     = '0;
          state_d   = ST_SHIFT;
          fd_pend_d = (row_q == row_w_c'(rps_c-1));
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!i_enable) begin
      state_d      = ST_IDLE;
      wr_en_d      = 1'b0;
      err_d        = 1'b0;
      fd_pend_d    = 1'b0;
      frame_done_d = 1'b0;
    end
    busy_d = wr_en_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < sync_stages_p; i++) sync_q[i] <= '0;
      samp_q       <= '0;
      clk_rise_q   <= 1'b0;
      stb_rise_q   <= 1'b0;
      state_q      <= ST_IDLE;
      for (int l = 0; l < lanes_c; l++) sr_q[l] <= '0;
      for (int j = 0; j < npix_c*3; j++) rb_q[j] <= '0;
      col_q        <= '0;
      plane_q      <= '0;
      row_q        <= '0;
      row_vld_q    <= 1'b0;
      idx_q        <= '0;
      err_q        <= 1'b0;
      wr_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      fd_pend_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      samp_q       <= samp_d;
      clk_rise_q   <= clk_rise_d;
      stb_rise_q   <= stb_rise_d;
      state_q      <= state_d;
      sr_q         <= sr_d;
      rb_q         <= rb_d;
      col_q        <= col_d;
      plane_q      <= plane_d;
      row_q        <= row_d;
      row_vld_q    <= row_vld_d;
      idx_q        <= idx_d;
      err_q        <= err_d;
      wr_en_q      <= wr_en_d;
      busy_q       <= busy_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      fd_pend_q    <= fd_pend_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_wr_en      = wr_en_q;
  assign o_frame_done = frame_done_q;
  assign o_err        = err_q;
  assign o_busy       = busy_q;

endmodule

// File: doc/hub75_rx_capture.md
# hub75_rx_capture

Receive-side HUB75 capture block: oversamples an incoming HUB75 bus (serial clock, strobe, OE, row select, dual-segment RGB) on the system clock and rebuilds full-depth pixels from the bit planes it sees. Each completed row is emitted on a framebuffer write port whose format matches `hub75_driver`'s `i_framebuf_wr_*` inputs. The block has two uses:

- closing a loopback around `hub75_color_tx`/`hub75_timer` in hardware and simulation;
- acting as the input stage of a panel-chaining bridge.

## Interface
Parameters:
- `hpixel_p`, 64: pixels per row (serial clocks per plane).
- `vpixel_p`, 64: display height.
- `bpp_p`, 8: bits per colour channel (planes per row).
- `segments_p`, 2: display segments; rows per segment `rps = vpixel_p/segments_p` (32).
- `sync_stages_p`, 2: input synchronizer depth, minimum 2.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `i_enable`, in, 1: capture enable.
- `I_CLK`, `I_STB`, `I_OE`, in, 1 each: HUB75 serial clock, latch strobe, output enable (active low).
- `I_A`, `I_B`, `I_C`, `I_D`, `I_E`, in, 1 each: row select. Row = {A,B,C,D,E}, with A as MSB, matching `hub75_timer` packing.
- `I_R1`, `I_G1`, `I_B1`, in, 1 each: segment 0 colour data.
- `I_R2`, `I_G2`, `I_B2`, in, 1 each: segment 1 colour data.
- `o_wr_addr`, out, `$clog2(hpixel_p*vpixel_p)`: framebuffer write address.
- `o_wr_data`, out, `3*bpp_p`: pixel packed {R,G,B}.
- `o_wr_en`, out, 1: write strobe, one pixel per asserted cycle.
- `o_frame_done`, out, 1: one-cycle pulse after the last pixel of row `rps-1` is written.
- `o_err`, out, 1: sticky protocol error; cleared only by reset or by `i_enable` falling.
- `o_busy`, out, 1: high while in DUMP.

## Operation
- **Synchronization:** all HUB75 inputs pass through `sync_stages_p` flops, then one edge-detect register. Sampled data is taken from the synchronized copies in the same cycle the edge is detected.
- **Shift register:** `segments_p*3*hpixel_p` bits. On each detected `I_CLK` rising edge:
  - every lane shifts up one position; the new bit enters index 0;
  - the column counter increments, saturating at `hpixel_p`.
  - After `hpixel_p` shifts, index c holds column c, so the first bit shifted lands in column `hpixel_p-1`.
- **Latch event (detected `I_STB` rising edge):**
  1. Capture the row address.
  2. If the row differs from the stored row, or no row is stored yet: set plane counter to 0 and store the new row.
  3. If the column counter ≠ `hpixel_p`: set `o_err`, discard the plane, set plane counter to 0.
  4. Otherwise write shift-register bit c, lane (s, colour) into bit `plane` of row buffer pixel [s][c][colour], then increment the plane counter.
  5. Clear the column counter.
- **Plane order:** LSB first, plane counter values 0..`bpp_p-1`. When plane `bpp_p-1` merges, the plane counter wraps to 0 and the FSM enters DUMP.
- **Row buffer:** `segments_p*hpixel_p*3*bpp_p` bits. Bits not rewritten in the current row keep their old value.
- **FSM:**
  - IDLE: `i_enable`=0. Counters are cleared, `o_err` is cleared, inputs are ignored. Goes to SHIFT when `i_enable`=1.
  - SHIFT: capture as described above. Goes to DUMP after the final plane merges.
  - DUMP: emits `segments_p*hpixel_p` writes, one per cycle, in order segment 0 col 0..`hpixel_p-1`, then segment 1. Returns to SHIFT after the last write.
  - Any state goes to IDLE when `i_enable`=0. A DUMP in progress is abandoned with no further writes.
- **Write address:** `(s*rps + row)*hpixel_p + col`. `o_wr_data` = {R[s][col], G[s][col], B[s][col]}.
- **Shifting during DUMP:** `I_CLK` edges continue into the shift register (the row buffer is separate). A latch event during DUMP sets `o_err` and is dropped.
- **Frame done:** `o_frame_done` pulses on the cycle after the last DUMP write when row = `rps-1`.
- **`I_OE`:** used for error checking only. A `I_CLK` edge is accepted whether `I_OE` is high or low. A latch event while `I_OE`=0 (display active) sets `o_err` but is otherwise processed normally.

## Timing
- **Reset values:**
  - `o_wr_addr`, `o_wr_data`, `o_wr_en`, `o_frame_done`, `o_err`, `o_busy` = 0;
  - FSM in IDLE;
  - counters = 0; stored row invalid.
- **Input timing requirement:** `I_CLK` high and low phases must each last ≥ 2 `clk` cycles. `I_STB` high must last ≥ 2 cycles. The data-to-edge relationship follows the driver, with data stable around the rising edge.
- **Edge latency:** input pin edge to internal edge pulse = `sync_stages_p`+1 cycles.
- **Merge latency:** latch pulse to row buffer updated = 1 cycle. The DUMP entry cycle follows.
- **Write outputs:** the first `o_wr_en` is 1 cycle after DUMP entry. Then `segments_p*hpixel_p` consecutive high cycles (128 at defaults). `o_busy` covers exactly those cycles.
- **Output registration:** all outputs are registered.
- **Simultaneous edges:** an `I_CLK` edge and an `I_STB` edge in the same cycle are handled as shift first, then latch.

## Test plan
- **Single row loopback:** drive 8 planes LSB-first for row 5, with segment 0 col 0 R=0xA5 and segment 1 col 63 B=0x3C, all else 0. Expect 128 writes; addr 320 data 0xA50000; addr 2431 data 0x00003C; `o_err`=0.
- **Full frame:** drive 32 rows × 8 planes with an incrementing pattern. Expect 4096 writes covering addresses 0..4095 exactly once each, and one `o_frame_done` pulse after the row-31 dump.
- **Short plane:** issue 63 clocks then a latch. Expect `o_err`=1, no DUMP. Then send a correct 8-plane row: expect normal writes while `o_err` stays 1.
- **Row change mid-row:** send 3 planes for row 2, then 8 planes for row 3. Expect only row-3 writes (addresses 192..255 and 2240..2303); no `o_err`.
- **Latch during DUMP:** strobe 10 cycles after DUMP entry. Expect `o_err`=1 and the dump still completing all 128 writes.
- **Disable and reset mid-DUMP:** deassert `i_enable` mid-DUMP, expect `o_wr_en`=0 next cycle and `o_err` cleared. Repeat with `rst_n` low, expect all outputs 0 immediately.
